sram_serial_ctrl: RTL and testbench

Serial command front-end that drives the 1RW OpenRAM macro (32+1 bit data, 9-bit address, 4 byte masks plus a spare bit) on the test chip.
- Deserialises a fixed-length command frame from a pin-limited interface.
- Issues exactly one SRAM access per frame.
- For reads, captures the macro's dout and serialises it back out.
- Sits directly upstream of the SRAM macro; all of the macro's control and data inputs come only from this block.

---
 rtl/sram_serial_ctrl_pkg.sv | 33 +++
 rtl/sram_serial_ctrl_piso.sv | 43 ++++
 rtl/sram_serial_ctrl.sv | 173 +++++++++++++++++
 tb/tb_sram_serial_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_serial_ctrl_pkg.sv
// Shared types and frame layout for the serial SRAM command front-end.
// Frame offsets move up by one when SRAM_SERIAL_CTRL_PARITY_EN adds the trailing parity bit.
package sram_serial_ctrl_pkg;

    localparam int DEF_ADDR_WIDTH = 9;
    localparam int DEF_DATA_WIDTH = 33;
    localparam int DEF_NUM_WMASKS = 4;

`ifdef SRAM_SERIAL_CTRL_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // Field offsets within the frame, counted from the last bit shifted in.
    localparam int DATA_LSB   = PARITY_BITS;
    localparam int SPARE_BIT  = DATA_LSB + DEF_DATA_WIDTH;
    localparam int WMASK_LSB  = SPARE_BIT + 1;
    localparam int ADDR_LSB   = WMASK_LSB + DEF_NUM_WMASKS;
    localparam int OP_BIT     = ADDR_LSB + DEF_ADDR_WIDTH;
    localparam int FRAME_BITS = OP_BIT + 1;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [1:0] {
        LOAD,
        ISSUE,
        WAIT,
        SHIFT_OUT
    } state_t;

endpackage

// File: rtl/sram_serial_ctrl_piso.sv
// Parallel-load, serial-out shifter for captured SRAM read data, MSB first.
// cnt holds the number of bits still to follow the one currently on sout.
module sram_serial_ctrl_piso #(
    parameter int DATA_WIDTH = 33,
    parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  shift,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  sout,
    output logic                  sout_valid,
    output logic                  last,
    output logic [CNT_W-1:0]      cnt
);

    logic [DATA_WIDTH-1:0] sreg;

    // sout is taken straight from the register MSB; shifting in zeros leaves it low when idle.
    assign sout = sreg[DATA_WIDTH-1];
    assign last = sout_valid && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg       <= '0;
            sout_valid <= 1'b0;
            cnt        <= '0;
        end else if (load) begin
            sreg       <= data;
            sout_valid <= 1'b1;
            cnt        <= CNT_W'(DATA_WIDTH - 1);
        end else if (shift && sout_valid) begin
            sreg <= {sreg[DATA_WIDTH-2:0], 1'b0};
            if (cnt == '0) begin
                sout_valid <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_serial_ctrl.sv
// Serial command front-end for the 1RW OpenRAM macro: one frame in, one access, reads serialised out.
// Optional trailing even-parity bit enabled by SRAM_SERIAL_CTRL_PARITY_EN.
module sram_serial_ctrl
    import sram_serial_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_WMASKS = DEF_NUM_WMASKS
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  sin,
    input  logic                  sin_valid,
    output logic                  busy,
    output logic                  sout,
    output logic                  sout_valid,
    output logic                  done,
    output logic                  err,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic                  sram_spare_wen0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    localparam int CNT_W  = $clog2(FRAME_BITS);
    localparam int PCNT_W = $clog2(DATA_WIDTH);

    state_t                state, state_n;
    logic [CNT_W-1:0]      bit_cnt, bit_cnt_n;
    logic [FRAME_BITS-2:0] frame, frame_n;
    logic [FRAME_BITS-1:0] frame_shift;
    logic                  frame_ok;

    logic                  busy_n, done_n, err_n;
    logic                  csb_n, web_n, spare_n;
    logic [NUM_WMASKS-1:0] wmask_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic [DATA_WIDTH-1:0] din_n;

    logic                  piso_load, piso_shift, piso_last;
    logic [PCNT_W-1:0]     piso_cnt;

    // Only the first FRAME_BITS-1 bits are stored; the final bit is decoded straight off sin.
    assign frame_shift = {frame, sin};

`ifdef SRAM_SERIAL_CTRL_PARITY_EN
    assign frame_ok = ~^frame_shift;
`else
    assign frame_ok = 1'b1;
`endif

    assign piso_shift = (state == SHIFT_OUT);

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        frame_n   = frame;
        csb_n     = 1'b1;
        web_n     = sram_web0;
        wmask_n   = sram_wmask0;
        spare_n   = sram_spare_wen0;
        addr_n    = sram_addr0;
        din_n     = sram_din0;
        done_n    = 1'b0;
        err_n     = 1'b0;
        piso_load = 1'b0;

        unique case (state)
            LOAD: begin
                if (sin_valid) begin
                    frame_n = frame_shift[FRAME_BITS-2:0];
                    if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
                        bit_cnt_n = '0;
                        if (frame_ok) begin
                            state_n = ISSUE;
                            csb_n   = 1'b0;
                            web_n   = (frame_shift[OP_BIT] != OP_WRITE);
                            addr_n  = frame_shift[ADDR_LSB +: ADDR_WIDTH];
                            din_n   = frame_shift[DATA_LSB +: DATA_WIDTH];
                            // Reads must never carry a live write mask into the macro.
                            if (frame_shift[OP_BIT] == OP_WRITE) begin
                                wmask_n = frame_shift[WMASK_LSB +: NUM_WMASKS];
                                spare_n = frame_shift[SPARE_BIT];
                            end else begin
                                wmask_n = '0;
                                spare_n = 1'b0;
                            end
                        end else begin
                            err_n = 1'b1;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            ISSUE: begin
                state_n = WAIT;
            end
            WAIT: begin
                if (sram_web0) begin
                    piso_load = 1'b1;
                    state_n   = SHIFT_OUT;
                end else begin
                    done_n  = 1'b1;
                    state_n = LOAD;
                end
            end
            SHIFT_OUT: begin
                // done is registered, so raise it one bit early to line up with the last sout bit.
                if (piso_cnt == PCNT_W'(1)) begin
                    done_n = 1'b1;
                end
                if (piso_last) begin
                    state_n = LOAD;
                end
            end
            default: begin
                state_n = LOAD;
            end
        endcase

        busy_n = (state_n != LOAD);
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            state           <= LOAD;
            bit_cnt         <= '0;
            frame           <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
            sram_csb0       <= 1'b1;
            sram_web0       <= 1'b1;
            sram_wmask0     <= '0;
            sram_spare_wen0 <= 1'b0;
            sram_addr0      <= '0;
            sram_din0       <= '0;
        end else begin
            state           <= state_n;
            bit_cnt         <= bit_cnt_n;
            frame           <= frame_n;
            busy            <= busy_n;
            done            <= done_n;
            err             <= err_n;
            sram_csb0       <= csb_n;
            sram_web0       <= web_n;
            sram_wmask0     <= wmask_n;
            sram_spare_wen0 <= spare_n;
            sram_addr0      <= addr_n;
            sram_din0       <= din_n;
        end
    end

    sram_serial_ctrl_piso #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_W      (PCNT_W)
    ) u_piso (
        .clk        (clk0),
        .rst        (rst0),
        .load       (piso_load),
        .shift      (piso_shift),
        .data       (sram_dout0),
        .sout       (sout),
        .sout_valid (sout_valid),
        .last       (piso_last),
        .cnt        (piso_cnt)
    );

endmodule

// File: tb/tb_sram_serial_ctrl.sv
// Directed bench for sram_serial_ctrl with a behavioural 1RW SRAM macro model.
// Define SRAM_SERIAL_CTRL_PARITY_EN to build the parity frame format and its reject case.
module tb_sram_serial_ctrl;

`ifdef SRAM_SERIAL_CTRL_PARITY_EN
    localparam int FB = 49;
`else
    localparam int FB = 48;
`endif

    logic        clk0 = 1'b0;
    logic        rst0 = 1'b1;
    logic        sin = 1'b0;
    logic        sin_valid = 1'b0;
    logic        busy, sout, sout_valid, done, err;
    logic        sram_csb0, sram_web0, sram_spare_wen0;
    logic [3:0]  sram_wmask0;
    logic [8:0]  sram_addr0;
    logic [32:0] sram_din0;
    logic [32:0] sram_dout0 = '0;

    int n_chk  = 0;
    int n_pass = 0;
    int csb_lows = 0;

    always #5 clk0 = ~clk0;

    sram_serial_ctrl dut (
        .clk0            (clk0),
        .rst0            (rst0),
        .sin             (sin),
        .sin_valid       (sin_valid),
        .busy            (busy),
        .sout            (sout),
        .sout_valid      (sout_valid),
        .done            (done),
        .err             (err),
        .sram_csb0       (sram_csb0),
        .sram_web0       (sram_web0),
        .sram_wmask0     (sram_wmask0),
        .sram_spare_wen0 (sram_spare_wen0),
        .sram_addr0      (sram_addr0),
        .sram_din0       (sram_din0),
        .sram_dout0      (sram_dout0)
    );

    // Macro model: samples on posedge while csb0 is low, read data appears on the following negedge.
    logic [32:0] mem [512];
    logic        rd_pend = 1'b0;
    logic [8:0]  rd_addr = '0;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = '0;
    end

    always @(posedge clk0) begin
        if (!sram_csb0) begin
            csb_lows <= csb_lows + 1;
            if (!sram_web0) begin
                for (int b = 0; b < 4; b++)
                    if (sram_wmask0[b]) mem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
                if (sram_spare_wen0) mem[sram_addr0][32] <= sram_din0[32];
                rd_pend <= 1'b0;
            end else begin
                rd_pend <= 1'b1;
                rd_addr <= sram_addr0;
            end
        end else begin
            rd_pend <= 1'b0;
        end
    end

    always @(negedge clk0) begin
        if (rd_pend) sram_dout0 <= mem[rd_addr];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [FB-1:0] mk_frame(input logic op, input logic [8:0] addr,
                                               input logic [3:0] wm, input logic sp,
                                               input logic [32:0] d);
        logic [47:0] b;
        b = {op, addr, wm, sp, d};
`ifdef SRAM_SERIAL_CTRL_PARITY_EN
        return {b, ^b};
`else
        return b;
`endif
    endfunction

    // Called at a negedge; returns at the negedge of cycle 1 (one half-cycle after the last bit is taken).
    task automatic send_frame(input logic [FB-1:0] f, input int unsigned gap_max);
        int unsigned g;
        for (int i = FB - 1; i >= 0; i--) begin
            if (gap_max > 0) begin
                g = $urandom_range(gap_max, 0);
                sin_valid = 1'b0;
                repeat (g) begin
                    sin = 1'($urandom);
                    @(negedge clk0);
                end
            end
            sin = f[i];
            sin_valid = 1'b1;
            @(negedge clk0);
        end
        sin_valid = 1'b0;
        sin = 1'b0;
    endtask

    task automatic do_write(input logic [8:0] addr, input logic [3:0] wm, input logic sp,
                            input logic [32:0] d, input int unsigned gap_max);
        int c0;
        c0 = csb_lows;
        send_frame(mk_frame(1'b1, addr, wm, sp, d), gap_max);
        chk("wr_csb_c1", sram_csb0, 0);
        chk("wr_web_c1", sram_web0, 0);
        chk("wr_addr", sram_addr0, addr);
        chk("wr_din", sram_din0, d);
        chk("wr_wmask", sram_wmask0, wm);
        chk("wr_spare", sram_spare_wen0, sp);
        chk("wr_busy_c1", busy, 1);
        chk("wr_err_c1", err, 0);
        @(negedge clk0);
        chk("wr_csb_c2", sram_csb0, 1);
        chk("wr_done_c2", done, 0);
        @(negedge clk0);
        chk("wr_done_c3", done, 1);
        chk("wr_busy_c3", busy, 0);
        chk("wr_one_access", csb_lows - c0, 1);
    endtask

    // rst_at < 0: full readback; otherwise reset is raised while sout carries bit index rst_at.
    task automatic do_read(input logic [8:0] addr, input logic [32:0] exp,
                           input bit noise, input int rst_at);
        logic [32:0] got;
        int nbits, first, cyc, busy_bad, done_ok, done_bad;
        got = '0; nbits = 0; first = -1; cyc = 1; busy_bad = 0; done_ok = 0; done_bad = 0;
        send_frame(mk_frame(1'b0, addr, 4'hF, 1'b1, {1'($urandom), 32'($urandom)}), 0);
        chk("rd_csb_c1", sram_csb0, 0);
        chk("rd_web_c1", sram_web0, 1);
        chk("rd_addr", sram_addr0, addr);
        chk("rd_wmask_forced", sram_wmask0, 0);
        chk("rd_spare_forced", sram_spare_wen0, 0);
        chk("rd_busy_c1", busy, 1);
        while (nbits < 33 && cyc <= 40) begin
            if (noise && busy) begin
                sin = ~sin;
                sin_valid = 1'b1;
            end else begin
                sin_valid = 1'b0;
            end
            if (sout_valid) begin
                if (first < 0) first = cyc;
                got = {got[31:0], sout};
                nbits++;
                if (!busy) busy_bad++;
                if (done) begin
                    if (nbits == 33) done_ok++;
                    else done_bad++;
                end
                if (rst_at >= 0 && nbits == rst_at + 1) begin
                    rst0 = 1'b1;
                    sin_valid = 1'b0;
                    @(negedge clk0);
                    chk("rst_partial_bits", got[20:0], exp[32:12]);
                    chk("rst_sout_valid", sout_valid, 0);
                    chk("rst_busy", busy, 0);
                    chk("rst_csb", sram_csb0, 1);
                    chk("rst_done", done, 0);
                    rst0 = 1'b0;
                    return;
                end
            end
            if (nbits < 33) begin
                @(negedge clk0);
                cyc++;
            end
        end
        chk("rd_bits_seen", nbits, 33);
        chk("rd_first_cycle", first, 3);
        chk("rd_data", got, exp);
        chk("rd_busy_during", busy_bad, 0);
        chk("rd_done_last", {done_bad[15:0], done_ok[15:0]}, 1);
        @(negedge clk0);
        sin_valid = 1'b0;
        chk("rd_end_valid", sout_valid, 0);
        chk("rd_end_busy", busy, 0);
        chk("rd_end_done", done, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk0);
        chk("rst_busy0", busy, 0);
        chk("rst_sout_valid0", sout_valid, 0);
        chk("rst_sout0", sout, 0);
        chk("rst_done0", done, 0);
        chk("rst_err0", err, 0);
        chk("rst_csb0", sram_csb0, 1);
        chk("rst_web0", sram_web0, 1);
        chk("rst_addr0", sram_addr0, 0);
        chk("rst_din0", sram_din0, 0);
        chk("rst_wmask0", {sram_wmask0, sram_spare_wen0}, 0);
        rst0 = 1'b0;
        @(negedge clk0);

        do_write(9'h005, 4'hF, 1'b1, 33'h1_DEADBEEF, 0);
        do_read(9'h005, 33'h1_DEADBEEF, 1'b0, -1);

        // Back-to-back writes; the second frame starts in the done cycle of the first.
        do_write(9'h009, 4'hF, 1'b1, 33'h0_AAAAAAAA, 0);
        do_write(9'h009, 4'h2, 1'b0, 33'h0_11223344, 0);
        do_read(9'h009, 33'h0_AAAA33AA, 1'b0, -1);

        do_write(9'h1A3, 4'h5, 1'b1, 33'h1_CAFEF00D, 10);
        do_read(9'h1A3, 33'h1_00FE000D, 1'b0, -1);

        do_read(9'h005, 33'h1_DEADBEEF, 1'b1, -1);
        do_read(9'h009, 33'h0_AAAA33AA, 1'b0, -1);

        do_read(9'h005, 33'h1_DEADBEEF, 1'b0, 20);
        do_read(9'h1A3, 33'h1_00FE000D, 1'b0, -1);

        // Partial frame discarded by reset.
        for (int i = 0; i < 20; i++) begin
            sin = 1'($urandom);
            sin_valid = 1'b1;
            @(negedge clk0);
        end
        sin_valid = 1'b0;
        rst0 = 1'b1;
        @(negedge clk0);
        chk("midframe_rst_busy", busy, 0);
        chk("midframe_rst_csb", sram_csb0, 1);
        rst0 = 1'b0;
        @(negedge clk0);
        do_write(9'h010, 4'hF, 1'b0, 33'h0_12345678, 0);
        do_read(9'h010, 33'h0_12345678, 1'b0, -1);

`ifdef SRAM_SERIAL_CTRL_PARITY_EN
        begin
            logic [FB-1:0] bad;
            int c0, dones;
            c0 = csb_lows;
            dones = 0;
            bad = mk_frame(1'b1, 9'h005, 4'hF, 1'b1, 33'h0_00000000);
            bad[0] = ~bad[0];
            send_frame(bad, 0);
            chk("par_err_c1", err, 1);
            chk("par_csb_c1", sram_csb0, 1);
            chk("par_busy_c1", busy, 0);
            if (done) dones++;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk0);
                if (done) dones++;
            end
            chk("par_err_pulse", err, 0);
            chk("par_no_done", dones, 0);
            chk("par_no_access", csb_lows - c0, 0);
            do_read(9'h005, 33'h1_DEADBEEF, 1'b0, -1);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
